pe_mac_sys: RTL

- Next-generation systolic processing element for the matrix-multiply array.
- Holds a double-buffered, parametrised-depth weight memory. Consumes a stream of A operands through a valid/ready handshake and forwards each A to the neighbouring PE.
- Multiplies each A by the weight at the current step and accumulates signed fixed-point products over K_LEN steps, then emits a saturated result C.
- Adds to the previous PE: width/depth/length generalisation, bank swapping, backpressure on every port, saturation and write-error flagging.

---
 rtl/pe_pkg.sv | 40 ++++
 rtl/pe_mac_unit.sv | 23 ++
 rtl/pe_mac_sys.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the systolic MAC processing element.
package pe_pkg;

  // Compute FSM: IDLE while no partial sum is held, ACC while accumulating.
  typedef enum logic {
    IDLE = 1'b0,
    ACC  = 1'b1
  } pe_state_t;

  // Working width of the saturation helper. It must cover the widest accumulator in use.
  localparam int SAT_W     = 128;
  localparam int SAT_OUT_W = 64;

  // Accumulator width: a full product plus enough headroom for K_LEN additions.
  function automatic int acc_w(input int data_w, input int k_len);
    return 2 * data_w + $clog2(k_len) + 1;
  endfunction

  // Drop the fractional bits with an arithmetic shift (floor), then clamp the result
  // to the signed data_w range.
  function automatic logic signed [SAT_OUT_W-1:0] sat_trunc(
    input logic signed [SAT_W-1:0] v,
    input int                      data_w,
    input int                      frac_w
  );
    logic signed [SAT_W-1:0] shifted;
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    shifted = v >>> frac_w;
    hi      = (128'sd1 <<< (data_w - 1)) - 128'sd1;
    lo      = -(128'sd1 <<< (data_w - 1));
    if (shifted > hi) begin
      shifted = hi;
    end else if (shifted < lo) begin
      shifted = lo;
    end
    return SAT_OUT_W'(shifted);
  endfunction

endpackage

// File: rtl/pe_mac_unit.sv
// Combinational datapath: signed multiply, accumulate, and saturated result extraction.
module pe_mac_unit
  import pe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int ACC_W  = 67
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] w,
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [ACC_W-1:0]  acc_next,
  output logic signed [DATA_W-1:0] c_sat
);

  logic signed [2*DATA_W-1:0] prod;

  // Full-precision product. Both operands are sign-extended before the multiply.
  assign prod     = (2*DATA_W)'(a) * (2*DATA_W)'(w);
  assign acc_next = acc + ACC_W'(prod);
  assign c_sat    = DATA_W'(sat_trunc(SAT_W'(acc_next), DATA_W, FRAC_W));

endmodule

// File: rtl/pe_mac_sys.sv
// Systolic PE: double-buffered weights, A forwarding, K_LEN-step signed fixed-point MAC
// with a saturated C result, deferred bank swap, and sticky flagging of illegal writes.
module pe_mac_sys
  import pe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int FRAC_W = 16,
  parameter int DEPTH  = 4,
  parameter int K_LEN  = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [DATA_W-1:0]    a_in,
  input  logic                        a_valid,
  output logic                        a_ready,
  output logic signed [DATA_W-1:0]    a_out,
  output logic                        a_out_valid,
  input  logic                        a_out_ready,
  input  logic signed [DATA_W-1:0]    w_in,
  input  logic                        w_we,
  input  logic [$clog2(DEPTH)-1:0]    w_addr,
  input  logic                        w_bank,
  input  logic                        swap,
  output logic                        act_bank,
  output logic signed [DATA_W-1:0]    c_out,
  output logic                        c_valid,
  input  logic                        c_ready,
  output logic                        wr_err
);

  localparam int AW    = $clog2(DEPTH);
  localparam int KW    = (K_LEN > 1) ? $clog2(K_LEN) : 1;
  localparam int ACC_W = acc_w(DATA_W, K_LEN);

  // Two weight banks. Entries are not reset.
  logic signed [DATA_W-1:0] mem [2][DEPTH];

  pe_state_t                state;
  logic [KW-1:0]            k_p0;
  logic signed [ACC_W-1:0]  acc_p0;
  logic                     swap_pend;

  logic                     accept;
  logic                     last_k;
  logic                     swap_exec;
  logic                     w_blocked;
  logic                     w_ok;
  logic signed [DATA_W-1:0] w_cur;
  logic signed [ACC_W-1:0]  acc_next;
  logic signed [DATA_W-1:0] c_sat;

  // A is taken only when both downstream slots can take new data. The cycle in which a
  // pending swap executes is kept free of compute reads, so a_ready is low then.
  assign a_ready   = rst & (~a_out_valid | a_out_ready) & (~c_valid | c_ready)
                     & ~(swap_pend & (state == IDLE));
  assign accept    = a_valid & a_ready;
  assign last_k    = (k_p0 == KW'(K_LEN - 1));
  assign swap_exec = swap_pend & (state == IDLE);

  // Writes into the active bank during an accumulation would corrupt the result.
  // Such writes are dropped.
  assign w_blocked = w_we & (w_bank == act_bank) & (state != IDLE);
  assign w_ok      = w_we & ~w_blocked;

  // The compute read is combinational. A write in the same cycle becomes visible only
  // after the clock edge, so the read returns the old value.
  assign w_cur     = mem[act_bank][AW'(k_p0)];

  pe_mac_unit #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W),
    .ACC_W  (ACC_W)
  ) u_mac (
    .a        (a_in),
    .w        (w_cur),
    .acc      (acc_p0),
    .acc_next (acc_next),
    .c_sat    (c_sat)
  );

  // Weight memory write port.
  always_ff @(posedge clk) begin
    if (w_ok) begin
      mem[w_bank][w_addr] <= w_in;
    end
  end

  // Stage p0 -> p1: forward every accepted A to the neighbouring PE.
  // Valid stays high through a simultaneous drain and refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_out       <= '0;
      a_out_valid <= 1'b0;
    end else if (accept) begin
      a_out       <= a_in;
      a_out_valid <= 1'b1;
    end else if (a_out_ready) begin
      a_out_valid <= 1'b0;
    end
  end

  // Accumulation FSM. A final accept registers the saturated result and restarts the sum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      k_p0    <= '0;
      acc_p0  <= '0;
      c_out   <= '0;
      c_valid <= 1'b0;
    end else if (accept && last_k) begin
      state   <= IDLE;
      k_p0    <= '0;
      acc_p0  <= '0;
      c_out   <= c_sat;
      c_valid <= 1'b1;
    end else begin
      if (c_ready) begin
        c_valid <= 1'b0;
      end
      if (accept) begin
        state  <= ACC;
        k_p0   <= k_p0 + KW'(1);
        acc_p0 <= acc_next;
      end
    end
  end

  // Bank swap: the request is latched and executes at the next idle cycle.
  // Extra requests while one is pending merge into it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      act_bank  <= 1'b0;
      swap_pend <= 1'b0;
    end else if (swap_exec) begin
      act_bank  <= ~act_bank;
      swap_pend <= 1'b0;
    end else if (swap) begin
      swap_pend <= 1'b1;
    end
  end

  // Sticky error flag for dropped writes. Only reset clears it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_err <= 1'b0;
    end else if (w_blocked) begin
      wr_err <= 1'b1;
    end
  end

endmodule
